credit_tx: RTL

//   Transmit end of a credit-flow link feeding a remote receive FIFO.
//   - Upstream side: valid/ready stream; handshake rule matches our fifo block.
//   - Downstream side: valid-only data, with one-credit-per-pulse returns.
//   - Sends a word only when the remote FIFO is guaranteed a free slot, so the

---
 rtl/credit_tx.sv | 78 +++++++
 1 files changed

// File: rtl/credit_tx.sv
// Transmit side of a credit-based link: forwards upstream words to a remote FIFO
// only while credits remain, and tracks returned credits with overflow detection.
module credit_tx #(
   parameter  int WIDTH   = 32,
   parameter  int CREDITS = 8,
   localparam int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_in_val,
   output logic             data_in_rdy,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_val,
   input  logic             credit_ret,
   output logic [CNT_W-1:0] credits_avail,
   output logic             idle,
   output logic             credit_err
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_tx_data;
   logic             r_tx_val;
   logic             r_credit_err;

   logic             w_accept;
   logic             w_overflow;
   logic [CNT_W-1:0] w_cnt_next;

   // Ready looks only at the registered count so a same-cycle return never bypasses.
   assign data_in_rdy = (r_cnt != {CNT_W{1'b0}});
   assign w_accept    = data_in_val && data_in_rdy;
   assign w_overflow  = credit_ret && !w_accept && (r_cnt == FULL);

   // Next credit count: decrement on accept, increment on return, saturate at full.
   always_comb begin
      w_cnt_next = r_cnt;
      case ({w_accept, credit_ret})
         2'b10: w_cnt_next = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
         2'b01: begin
            if (w_overflow) begin
               w_cnt_next = r_cnt;
            end else begin
               w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: w_cnt_next = r_cnt;
      endcase
   end

   // Credit counter, transmit register and sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= FULL;
         r_tx_data    <= {WIDTH{1'b0}};
         r_tx_val     <= 1'b0;
         r_credit_err <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_next;
         r_tx_val <= w_accept;
         if (w_accept) begin
            r_tx_data <= data_in;
         end
         if (w_overflow) begin
            r_credit_err <= 1'b1;
         end
      end
   end

   assign tx_data       = r_tx_data;
   assign tx_val        = r_tx_val;
   assign credits_avail = r_cnt;
   assign credit_err    = r_credit_err;
   assign idle          = (r_cnt == FULL) && !r_tx_val;

endmodule
